dm_store_buffer: RTL
====================

# dm_store_buffer

Posted-write buffer between the store unit and the data-memory bus. Captures each aligned store (word address, byte mask, lane-positioned data) in a DEPTH-entry FIFO, merges consecutive stores to the same word, and drains entries to memory over a valid/ready handshake. The pipeline sees a single stall signal. Loads see a hazard flag while a matching store is still pending.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- clk_in  input  1  core clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- dm_wr_req_in  input  1  store request from the store unit.
- dm_addr_in  input  32  store byte address; bits [1:0] are ignored.
- dm_wr_mask_in  input  4  byte-lane enables; bit i enables data [8i+7:8i].
- dm_data_in  input  32  lane-positioned store data.
- wb_stall_out  output  1  store not accepted this cycle; upstream must hold its request.
- ld_req_in  input  1  load probe valid.
- ld_addr_in  input  32  load byte address.
- ld_hazard_out  output  1  a pending entry targets the load's word.
- bus_valid_out  output  1  head entry presented to memory.
- bus_ready_in  input  1  memory accepts the head entry.
- bus_addr_out  output  32  head word address, {addr[31:2],2'b00}.
- bus_mask_out  output  4  head byte mask.
- bus_data_out  output  32  head data.
- empty_out  output  1  no pending entries; used for fence and drain.
- count_out  output  $clog2(DEPTH)+1  number of pending entries.

## Operation
- Storage: DEPTH entries of {word_addr[29:0], mask[3:0], data[31:0]} plus read pointer, write pointer and count.
- Request validity: a request with dm_wr_mask_in == 0 is dropped. It is not enqueued and does not stall.
- Combine: a request combines when all of the following hold:
  - dm_wr_req_in = 1 and the mask is nonzero;
  - count_out ≥ 2;
  - dm_addr_in[31:2] equals the word address of the tail (newest) entry.
- Combine action:
  - Lanes with a mask bit set overwrite the tail's data bytes.
  - The tail mask becomes tail_mask | dm_wr_mask_in.
  - Count is unchanged.
- No combine into the head: the head may be mid-handshake, so a count of 1 never combines.
- Enqueue: a request that does not combine writes a new tail entry when count < DEPTH.
- Stall: wb_stall_out = dm_wr_req_in & |dm_wr_mask_in & full & ~combine. It is combinational, and a combine proceeds even when the buffer is full.
- Dequeue: happens when bus_valid_out & bus_ready_in at a clock edge.
  - bus_valid_out = ~empty.
  - Bus fields are driven directly from the head entry.
- Simultaneous enqueue and dequeue: allowed, and count is unchanged. Full status is evaluated on pre-edge state, so a full buffer stalls even if a dequeue happens that cycle.
- Hazard:
  - ld_hazard_out = ld_req_in & (any pending entry has word_addr == ld_addr_in[31:2]).
  - It is combinational on registered state and includes the head being dequeued this cycle.
- Pointers wrap modulo DEPTH. Count saturates by construction and never exceeds DEPTH.

## Timing
- Reset (asynchronous, while rst_n_in = 0):
  - pointers = 0, count_out = 0, empty_out = 1, bus_valid_out = 0;
  - bus_addr_out, bus_mask_out and bus_data_out = 0 (entry storage cleared).
- Reset during a bus handshake: bus_valid_out drops immediately, all pending entries are discarded, and no partial state survives.
- Latency: a store accepted at edge N into an empty buffer gives bus_valid_out = 1 from edge N through at least edge N+1.
- Throughput: one enqueue and one dequeue per cycle.
- Bus rule: bus_addr_out, bus_mask_out and bus_data_out stay stable while bus_valid_out = 1 and bus_ready_in = 0. bus_valid_out never drops without a handshake, except on reset.
- Combine takes effect at the same edge as the request.
- A 0 → 1 transition of ld_hazard_out follows enqueue with one edge of latency. A 1 → 0 transition follows the edge that dequeues the last matching entry.

## Test plan
- Single store:
  - Stimulus: dm_addr_in = 0x1000_0006, mask 4'b1100, data 0xABCD_0000, then bus_ready_in = 1 after 2 stall cycles.
  - Response: bus_addr_out = 0x1000_0004 and fields are held for 3 cycles. The entry leaves and empty_out returns to 1.
- Fill and stall:
  - Stimulus: bus_ready_in = 0 and DEPTH+1 stores to distinct words.
  - Response: count_out reaches 4 and wb_stall_out = 1 on the fifth store. After one handshake the fifth store enqueues, and entries drain in order.
- Combine:
  - Stimulus: bus_ready_in = 0, stores to 0x20 (mask 0001, 0x11), 0x40 (mask 0001, 0x22), 0x41 (mask 0010, 0x3300).
  - Response: count_out = 2 and the tail holds mask 0011, data 0x0000_3322.
- Combine while full:
  - Stimulus: buffer full, store to the tail word with mask 1000.
  - Response: wb_stall_out = 0, count_out stays 4, and the tail mask gains bit 3.
- Load hazard:
  - Stimulus: pending store to 0x80, then ld_addr_in = 0x83 and later 0x84.
  - Response: ld_hazard_out is 1 for 0x83 and 0 for 0x84. For 0x83 it clears after the edge that dequeues the 0x80 entry.
- Reset mid-handshake:
  - Stimulus: assert rst_n_in low with 3 entries pending and bus_valid_out = 1.
  - Response: bus_valid_out = 0 and count_out = 0 immediately. After release, new stores behave normally.

Source files
------------

// File: rtl/dm_store_buffer.sv
// dm_store_buffer
// Posted-write buffer between the store unit and the data-memory bus.
// Aligned stores are queued in a DEPTH-entry FIFO, a store to the same word
// as the newest entry is merged into it, and the oldest entry is presented
// on a valid/ready bus until memory accepts it.
//
// Ports:
//   clk_in, rst_n_in                  clock, asynchronous active-low reset
//   dm_wr_req_in/addr/mask/data       store request (lane-positioned data)
//   wb_stall_out                      store not accepted this cycle
//   ld_req_in, ld_addr_in             load probe
//   ld_hazard_out                     a pending entry targets the load word
//   bus_valid_out/ready_in            head-entry handshake to memory
//   bus_addr_out/mask_out/data_out    head entry fields
//   empty_out, count_out              occupancy
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       dm_wr_req_in,
    input  logic [31:0]                dm_addr_in,
    input  logic [3:0]                 dm_wr_mask_in,
    input  logic [31:0]                dm_data_in,
    output logic                       wb_stall_out,
    input  logic                       ld_req_in,
    input  logic [31:0]                ld_addr_in,
    output logic                       ld_hazard_out,
    output logic                       bus_valid_out,
    input  logic                       bus_ready_in,
    output logic [31:0]                bus_addr_out,
    output logic [3:0]                 bus_mask_out,
    output logic [31:0]                bus_data_out,
    output logic                       empty_out,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [29:0]   addr_q [DEPTH];
    logic [29:0]   addr_d [DEPTH];
    logic [3:0]    mask_q [DEPTH];
    logic [3:0]    mask_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          req_valid;
    logic          full;
    logic          empty;
    logic          combine;
    logic          enq;
    logic          deq;
    logic [PW-1:0] tail_ptr;
    logic [PW-1:0] offset;
    logic          hazard_hit;

    // Address LSBs are don't-care for word-granular matching.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{dm_addr_in[1:0], ld_addr_in[1:0]};

    always_comb begin
        req_valid = dm_wr_req_in && (dm_wr_mask_in != 4'b0000);
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        tail_ptr  = wr_ptr_q - PW'(1);
        // The head may be mid-handshake, so merging needs at least two entries.
        combine   = req_valid && (count_q >= CW'(2)) &&
                    (dm_addr_in[31:2] == addr_q[tail_ptr]);
        enq       = req_valid && !combine && !full;
        deq       = !empty && bus_ready_in;

        for (int i = 0; i < DEPTH; i++) begin
            addr_d[i] = addr_q[i];
            mask_d[i] = mask_q[i];
            data_d[i] = data_q[i];
        end

        if (combine) begin
            mask_d[tail_ptr] = mask_q[tail_ptr] | dm_wr_mask_in;
            for (int b = 0; b < 4; b++) begin
                if (dm_wr_mask_in[b]) begin
                    data_d[tail_ptr][8*b +: 8] = dm_data_in[8*b +: 8];
                end
            end
        end

        if (enq) begin
            addr_d[wr_ptr_q] = dm_addr_in[31:2];
            mask_d[wr_ptr_q] = dm_wr_mask_in;
            data_d[wr_ptr_q] = dm_data_in;
        end

        rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;

        count_d = count_q;
        if (enq && !deq) begin
            count_d = count_q + CW'(1);
        end else if (deq && !enq) begin
            count_d = count_q - CW'(1);
        end
    end

    // Hazard covers every live slot, including a head being dequeued now.
    always_comb begin
        hazard_hit = 1'b0;
        offset     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) && (addr_q[i] == ld_addr_in[31:2])) begin
                hazard_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                mask_q[i] <= '0;
                data_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                mask_q[i] <= mask_d[i];
                data_q[i] <= data_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wb_stall_out  = req_valid && full && !combine;
    assign ld_hazard_out = ld_req_in && hazard_hit;
    assign bus_valid_out = !empty;
    assign bus_addr_out  = {addr_q[rd_ptr_q], 2'b00};
    assign bus_mask_out  = mask_q[rd_ptr_q];
    assign bus_data_out  = data_q[rd_ptr_q];
    assign empty_out     = empty;
    assign count_out     = count_q;

endmodule
